sound_frame_reader: RTL and testbench

Read-side controller for the triple-buffered audio sample BRAMs. The 48 kHz writer fills buffers A/B/C in rotation and reports the buffer it is currently writing on `select`. This block runs in the 25 MHz processing domain and does the following:
- detects each completed frame;
- streams its `FRAME_LEN` samples from the completed BRAM over a valid/ready interface;
- absorbs the BRAM read latency with a small output FIFO;
- flags frames that are skipped or overwritten.

It replaces the ad-hoc address/enable muxing between the buffers and the spectral front end.

---
 rtl/sound_frame_reader.sv | 195 +++++++++++++++++++
 tb/tb_sound_frame_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_frame_reader.sv
// sound_frame_reader: read-side controller for the triple-buffered audio BRAMs.
// Detects completed frames from the writer's buffer select, streams FRAME_LEN
// samples from the finished buffer through a 4-deep show-ahead FIFO, and flags
// skipped (dropped) and overwritten (overrun) frames.
module sound_frame_reader #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 512,
   parameter int RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              RST_N,
   input  logic [1:0]        select,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_A_enable,
   output logic              bram_B_enable,
   output logic              bram_C_enable,
   input  logic [DATA_W-1:0] bram_A_out_data,
   input  logic [DATA_W-1:0] bram_B_out_data,
   input  logic [DATA_W-1:0] bram_C_out_data,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              sample_last,
   output logic              busy,
   output logic              frame_overrun,
   output logic [7:0]        frames_dropped
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   state_t                       state_q, state_d;
   logic [1:0]                   sel_s1_q, sel_s2_q, sel_prev_q, arm_q;
   logic [1:0]                   last_done_q, rd_buf_q;
   logic                         pend_q, ovr_q;
   logic [7:0]                   drop_q;
   logic [ADDR_W-1:0]            addr_q;
   logic [RD_LAT-1:0]            pipe_vld_q, pipe_last_q;
   logic [RD_LAT-1:0][1:0]       pipe_buf_q;
   logic [3:0][DATA_W-1:0]       fifo_data_q;
   logic [3:0]                   fifo_last_q;
   logic [1:0]                   wptr_q, rptr_q;
   logic [2:0]                   cnt_q, inflight;
   logic                         chg, start, issue, push, pop;
   logic [DATA_W-1:0]            cap_data;

   // Change detection is held off until the synchronizer has refilled after
   // reset, so a select that is already stable does not look like a new frame.
   assign chg   = (arm_q == 2'd3) && (sel_s2_q != sel_prev_q);
   assign start = (state_q == S_IDLE) && pend_q && !chg;

   // Two-flop synchronizer on select, previous-value register, arming counter
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         sel_s1_q   <= '0;
         sel_s2_q   <= '0;
         sel_prev_q <= '0;
         arm_q      <= '0;
      end else begin
         sel_s1_q   <= select;
         sel_s2_q   <= sel_s1_q;
         sel_prev_q <= sel_s2_q;
         if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
      end
   end

   // Frame bookkeeping: pending frame, drop counter, read buffer, address, overrun
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         last_done_q <= '0;
         pend_q      <= 1'b0;
         drop_q      <= '0;
         rd_buf_q    <= '0;
         addr_q      <= '0;
         ovr_q       <= 1'b0;
      end else begin
         if (chg) begin
            last_done_q <= sel_prev_q;
            pend_q      <= 1'b1;
            if (pend_q && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
         end else if (start) begin
            pend_q <= 1'b0;
         end
         if (start) begin
            rd_buf_q <= last_done_q;
            addr_q   <= '0;
         end else if (issue) begin
            addr_q <= addr_q + 1'b1;
         end
         ovr_q <= (state_q != S_IDLE) && chg && (sel_s2_q == rd_buf_q);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_READ;
         S_READ:  if (issue && addr_q == LAST_ADDR) state_d = S_DRAIN;
         S_DRAIN: if (inflight == 3'd0 && cnt_q == 3'd0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: issue one address per cycle while FIFO space is reserved
   always_comb begin
      busy  = 1'b0;
      issue = 1'b0;
      case (state_q)
         S_READ: begin
            busy  = 1'b1;
            issue = (cnt_q + inflight) < 3'd4;
         end
         S_DRAIN: busy = 1'b1;
         default: ;
      endcase
   end

   assign bram_addr     = addr_q;
   assign bram_A_enable = issue && (rd_buf_q == 2'd0);
   assign bram_B_enable = issue && (rd_buf_q == 2'd1);
   assign bram_C_enable = issue && (rd_buf_q == 2'd2);

   // Count reads issued but not yet captured; they own a FIFO slot already
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + {2'b00, pipe_vld_q[i]};
   end

   // Read-latency tracking pipeline: valid, last tag and source buffer per read
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         pipe_buf_q  <= '0;
      end else begin
         pipe_vld_q[0]  <= issue;
         pipe_last_q[0] <= (addr_q == LAST_ADDR);
         pipe_buf_q[0]  <= rd_buf_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
            pipe_buf_q[i]  <= pipe_buf_q[i-1];
         end
      end
   end

   // Select the BRAM that was enabled RD_LAT cycles ago
   always_comb begin
      cap_data = '0;
      case (pipe_buf_q[RD_LAT-1])
         2'd0:    cap_data = bram_A_out_data;
         2'd1:    cap_data = bram_B_out_data;
         2'd2:    cap_data = bram_C_out_data;
         default: cap_data = '0;
      endcase
   end

   assign push         = pipe_vld_q[RD_LAT-1];
   assign sample_valid = (cnt_q != 3'd0);
   assign pop          = sample_valid && sample_ready;
   assign sample_data  = fifo_data_q[rptr_q];
   assign sample_last  = fifo_last_q[rptr_q];

   // Show-ahead output FIFO; overflow is impossible because issue reserves a slot
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         fifo_data_q <= '0;
         fifo_last_q <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
      end else begin
         if (push) begin
            fifo_data_q[wptr_q] <= cap_data;
            fifo_last_q[wptr_q] <= pipe_last_q[RD_LAT-1];
            wptr_q              <= wptr_q + 2'd1;
         end
         if (pop) rptr_q <= rptr_q + 2'd1;
         cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
      end
   end

   assign frame_overrun  = ovr_q;
   assign frames_dropped = drop_q;

endmodule

// File: tb/tb_sound_frame_reader.sv
// Scoreboard bench for sound_frame_reader: stimulus pushes expected samples,
// negedge monitors pop and compare whenever a sample is accepted.
module tb_sound_frame_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  sel, sel2;
   logic        ready, ready2, bp;
   logic [8:0]  addr1;
   logic        a_en, b_en, c_en;
   logic [15:0] a_d, b_d, c_d, sdata;
   logic        svalid, slast, busy, ovr;
   logic [7:0]  drop;
   logic [8:0]  addr2;
   logic        a_en2, b_en2, c_en2;
   logic [15:0] a2_s1, b2_s1, c2_s1, a2_d, b2_d, c2_d, sdata2;
   logic        svalid2, slast2, busy2, ovr2;
   logic [7:0]  drop2;

   logic [16:0] q1[$];
   logic [16:0] q2[$];
   int n_chk = 0, n_fail = 0;
   int cyc = 0, pops_tot = 0, infl = 0, ovr_cnt = 0, brun = 0, blen = 0;
   int first_en = -1, first_val = -1;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   sound_frame_reader #(.ADDR_W(9), .DATA_W(16), .FRAME_LEN(512), .RD_LAT(1)) u_dut (
      .clk(clk), .RST_N(rst_n), .select(sel), .bram_addr(addr1),
      .bram_A_enable(a_en), .bram_B_enable(b_en), .bram_C_enable(c_en),
      .bram_A_out_data(a_d), .bram_B_out_data(b_d), .bram_C_out_data(c_d),
      .sample_data(sdata), .sample_valid(svalid), .sample_ready(ready),
      .sample_last(slast), .busy(busy), .frame_overrun(ovr), .frames_dropped(drop));

   sound_frame_reader #(.ADDR_W(9), .DATA_W(16), .FRAME_LEN(8), .RD_LAT(2)) u_dut2 (
      .clk(clk), .RST_N(rst_n), .select(sel2), .bram_addr(addr2),
      .bram_A_enable(a_en2), .bram_B_enable(b_en2), .bram_C_enable(c_en2),
      .bram_A_out_data(a2_d), .bram_B_out_data(b2_d), .bram_C_out_data(c2_d),
      .sample_data(sdata2), .sample_valid(svalid2), .sample_ready(ready2),
      .sample_last(slast2), .busy(busy2), .frame_overrun(ovr2), .frames_dropped(drop2));

   // BRAM contents: buffer index in the top nibble, address below
   function automatic logic [15:0] bval(input int b, input int a);
      return 16'((b << 12) | a);
   endfunction

   // One-cycle BRAM models for the RD_LAT=1 instance
   always @(posedge clk) begin
      if (a_en) a_d <= bval(0, int'(addr1));
      if (b_en) b_d <= bval(1, int'(addr1));
      if (c_en) c_d <= bval(2, int'(addr1));
   end

   // Two-cycle BRAM models for the RD_LAT=2 instance
   always @(posedge clk) begin
      if (a_en2) a2_s1 <= bval(0, int'(addr2));
      if (b_en2) b2_s1 <= bval(1, int'(addr2));
      if (c_en2) c2_s1 <= bval(2, int'(addr2));
      a2_d <= a2_s1; b2_d <= b2_s1; c2_d <= c2_s1;
   end

   task automatic check_eq(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic push_frame(input int b, input int n, input bit second);
      for (int i = 0; i < n; i++) begin
         if (second) q2.push_back({i == n - 1, bval(b, i)});
         else        q1.push_back({i == n - 1, bval(b, i)});
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q1.delete();
      tick(2);
      rst_n = 1'b1;
      tick(5);
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while ((q1.size() != 0 || busy) && n < budget) begin tick(1); n++; end
      if (n >= budget) fail_now({name, "_timeout"});
      tick(2);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_addr"}, addr1, 0);
      check_eq({tag, "_enables"}, {a_en, b_en, c_en}, 0);
      check_eq({tag, "_sdata"}, sdata, 0);
      check_eq({tag, "_svalid"}, svalid, 0);
      check_eq({tag, "_slast"}, slast, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_overrun"}, ovr, 0);
      check_eq({tag, "_dropped"}, drop, 0);
   endtask

   // Monitor for the main instance
   initial begin
      bit          stall = 0;
      logic [15:0] held = '0;
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 0; infl = 0; brun = 0;
         end else begin
            if (stall) begin
               check_eq("stall_valid", svalid, 1);
               check_eq("stall_data", sdata, held);
            end
            check_eq("en_onehot", int'(a_en) + int'(b_en) + int'(c_en) <= 1, 1);
            if (a_en | b_en | c_en) begin
               infl++;
               check_eq("en_while_busy", busy, 1);
            end
            check_eq("in_flight_le4", infl <= 4, 1);
            if (svalid && ready) begin
               if (q1.size() == 0) fail_now("unexpected_sample");
               else begin
                  e = q1.pop_front();
                  check_eq("sample_data", sdata, e[15:0]);
                  check_eq("sample_last", slast, e[16]);
               end
               pops_tot++;
               infl--;
            end
            if (ovr) ovr_cnt++;
            if (busy) brun++;
            else begin
               if (brun != 0) blen = brun;
               brun = 0;
            end
            stall = svalid && !ready;
            held  = sdata;
         end
      end
   end

   // Monitor for the RD_LAT=2 instance
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if ((a_en2 | b_en2 | c_en2) && first_en < 0) first_en = cyc;
            if (svalid2 && first_val < 0) first_val = cyc;
            if (svalid2 && ready2) begin
               if (q2.size() == 0) fail_now("unexpected_sample2");
               else begin
                  e = q2.pop_front();
                  check_eq("sample_data2", sdata2, e[15:0]);
                  check_eq("sample_last2", slast2, e[16]);
               end
            end
         end
      end
   end

   initial begin
      int n, o0, base;
      rst_n = 1'b0; sel = 2'd0; sel2 = 2'd0; ready = 1'b1; ready2 = 1'b1; bp = 1'b0;
      tick(2);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      tick(5);

      // RD_LAT=2 instance, 8-sample frame from A
      push_frame(0, 8, 1'b1);
      sel2 = 2'd1;
      n = 0;
      while ((q2.size() != 0 || busy2) && n < 200) begin tick(1); n++; end
      if (n >= 200) fail_now("lat2_timeout");
      tick(2);
      check_eq("lat2_q_empty", q2.size(), 0);
      check_eq("lat2_first_valid_delay", first_val - first_en, 3);
      check_eq("lat2_dropped", drop2, 0);

      // Single frame from A with ready held high
      push_frame(0, 512, 1'b0);
      sel = 2'd1;
      wait_empty("single", 3000);
      check_eq("single_busy_len", blen, 515);
      check_eq("single_dropped", drop, 0);
      check_eq("single_busy_end", busy, 0);

      // Backpressure: frame B with 30% ready
      bp = 1'b1;
      push_frame(1, 512, 1'b0);
      sel = 2'd2;
      wait_empty("backpressure", 8000);
      bp = 1'b0;
      check_eq("bp_dropped", drop, 0);

      // Drop counting: 0->1->2 on consecutive cycles, only B is read
      sel = 2'd0;
      do_reset();
      push_frame(1, 512, 1'b0);
      sel = 2'd1;
      tick(1);
      sel = 2'd2;
      wait_empty("drop", 3000);
      tick(20);
      check_eq("drop_count", drop, 1);
      check_eq("drop_no_extra_frame", busy, 0);

      // Overrun: writer wraps back into A while A is read, next frame is C
      sel = 2'd0;
      do_reset();
      o0 = ovr_cnt;
      push_frame(0, 512, 1'b0);
      sel = 2'd1;
      n = 0;
      while (!busy && n < 50) begin tick(1); n++; end
      if (n >= 50) fail_now("overrun_start_timeout");
      tick(50);
      sel = 2'd2;
      tick(10);
      sel = 2'd0;
      push_frame(2, 512, 1'b0);
      wait_empty("overrun", 4000);
      check_eq("overrun_pulses", ovr_cnt - o0, 1);
      check_eq("overrun_dropped", drop, 1);

      // Reset in the middle of a frame read from A
      push_frame(0, 512, 1'b0);
      base = pops_tot;
      sel = 2'd1;
      n = 0;
      while (pops_tot - base < 200 && n < 2000) begin tick(1); n++; end
      if (n >= 2000) fail_now("midreset_timeout");
      #2 rst_n = 1'b0;
      q1.delete();
      #1 check_outputs_zero("midreset");
      tick(2);
      rst_n = 1'b1;
      tick(30);
      check_eq("post_reset_busy", busy, 0);
      check_eq("post_reset_valid", svalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
